// File: rtl/bc_bank_scheduler.sv
// Slot scheduler for the time-multiplexed FIR bank: sequences four band slots per accepted
// sample, gates the input handshake, strobes cascade latches and tracks priming/underrun.
module bc_bank_scheduler #(
    parameter int unsigned PRIME_FRAMES = 19,
    parameter int unsigned FCW          = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           enable,
    input  logic           in_valid,
    output logic           in_ready,
    output logic           load_in,
    output logic           flush,
    output logic [1:0]     slot,
    output logic [2:0]     lat_en,
    output logic           out_valid,
    output logic [FCW-1:0] frame_cnt,
    output logic           underrun
);

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StRun,
        StWait
    } state_e;

    localparam logic [FCW-1:0] CntMax = '1;
    localparam logic [1:0]     LastSlot = 2'd3;

    state_e         state_q, state_d;
    logic [1:0]     slot_q, slot_d;
    logic [FCW-1:0] cnt_q, cnt_d;
    logic           underrun_q, underrun_d;

    logic primed;
    logic at_boundary;

    assign primed      = 32'(cnt_q) >= PRIME_FRAMES;
    // A new sample may only enter between frames: while waiting, or in the last slot.
    assign at_boundary = (state_q == StWait) || ((state_q == StRun) && (slot_q == LastSlot));

    assign in_ready  = at_boundary & enable;
    assign load_in   = in_ready & in_valid;
    assign flush     = (state_q == StFlush);
    assign out_valid = (state_q == StRun) & primed;
    assign slot      = slot_q;
    assign frame_cnt = cnt_q;
    assign underrun  = underrun_q;

    // Each cascade stage latches once per frame, only while actually running.
    always_comb begin
        lat_en = 3'b000;
        if (state_q == StRun) begin
            unique case (slot_q)
                2'd0:    lat_en = 3'b010;
                2'd1:    lat_en = 3'b001;
                2'd2:    lat_en = 3'b000;
                2'd3:    lat_en = 3'b100;
                default: lat_en = 3'b000;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        unique case (state_q)
            StIdle: begin
                slot_d = 2'd0;
                if (enable) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                state_d = StWait;
                slot_d  = LastSlot;
            end
            StWait: begin
                if (load_in) begin
                    state_d = StRun;
                    slot_d  = 2'd0;
                end else if (!enable) begin
                    state_d = StIdle;
                    slot_d  = 2'd0;
                end
            end
            StRun: begin
                if (slot_q != LastSlot) begin
                    slot_d = slot_q + 2'd1;
                end else if (!enable) begin
                    state_d = StIdle;
                    slot_d  = 2'd0;
                end else if (in_valid) begin
                    slot_d = 2'd0;
                end else begin
                    state_d = StWait;
                end
            end
            default: begin
                state_d = StIdle;
                slot_d  = 2'd0;
            end
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        underrun_d = underrun_q;
        if (flush) begin
            cnt_d      = '0;
            underrun_d = 1'b0;
        end else begin
            if (load_in && (cnt_q != CntMax)) begin
                cnt_d = cnt_q + FCW'(1);
            end
            // Starvation only counts once the cascade has produced real output.
            if ((state_q == StRun) && (slot_q == LastSlot) && enable && !in_valid && primed) begin
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            slot_q     <= 2'd0;
            cnt_q      <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            cnt_q      <= cnt_d;
            underrun_q <= underrun_d;
        end
    end

endmodule

// File: tb/tb_bc_bank_scheduler.sv
// Scoreboard bench for bc_bank_scheduler: a sample/frame-level reference model predicts every
// cycle's outputs; a negedge monitor pops and compares them.
module tb_bc_bank_scheduler;

    localparam int PRIME = 19;
    localparam int CMAX  = 255;

    logic       clock;
    logic       drv_rst;
    logic       drv_en;
    logic       drv_v;
    logic       in_ready;
    logic       load_in;
    logic       flush;
    logic [1:0] slot;
    logic [2:0] lat_en;
    logic       out_valid;
    logic [7:0] frame_cnt;
    logic       underrun;

    bc_bank_scheduler #(
        .PRIME_FRAMES(PRIME),
        .FCW(8)
    ) dut (
        .clock(clock),
        .reset(drv_rst),
        .enable(drv_en),
        .in_valid(drv_v),
        .in_ready(in_ready),
        .load_in(load_in),
        .flush(flush),
        .slot(slot),
        .lat_en(lat_en),
        .out_valid(out_valid),
        .frame_cnt(frame_cnt),
        .underrun(underrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0] slot;
        logic       in_ready;
        logic       load_in;
        logic       flush;
        logic [2:0] lat_en;
        logic       out_valid;
        logic [7:0] frame_cnt;
        logic       underrun;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: the session is idle, flushing, waiting for a sample, or inside a 4-slot frame.
    localparam int MIdle  = 0;
    localparam int MFlush = 1;
    localparam int MWait  = 2;
    localparam int MFrame = 3;

    int m_phase;
    int m_pos;
    int m_count;
    bit m_starved;
    int band_of_slot[4] = '{2, 1, 4, 3};

    function automatic void check(input string name, input int unsigned act,
                                  input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endfunction

    task automatic model_reset();
        m_phase   = MIdle;
        m_pos     = 0;
        m_count   = 0;
        m_starved = 0;
    endtask

    function automatic bit model_boundary();
        return (m_phase == MWait) || (m_phase == MFrame && m_pos == 3);
    endfunction

    function automatic exp_t model_out(input logic en, input logic v, input logic rst);
        exp_t e;
        int   b;
        e = '0;
        if (rst) begin
            e.in_ready = model_boundary() && en;
            e.load_in  = e.in_ready && v;
            e.flush    = (m_phase == MFlush);
            e.slot     = (m_phase == MFrame) ? 2'(m_pos) : (m_phase == MWait) ? 2'd3 : 2'd0;
            if (m_phase == MFrame) begin
                // Cascade stage k latches while band k is being served.
                b = band_of_slot[m_pos];
                if (b <= 3) e.lat_en = 3'(1 << (b - 1));
            end
            e.out_valid = (m_phase == MFrame) && (m_count >= PRIME);
            e.frame_cnt = (m_count > CMAX) ? 8'(CMAX) : 8'(m_count);
            e.underrun  = m_starved;
        end
        return e;
    endfunction

    task automatic model_advance(input logic en, input logic v);
        bit load;
        load = model_boundary() && en && v;
        if (load) m_count++;
        case (m_phase)
            MIdle:  if (en) m_phase = MFlush;
            MFlush: begin
                m_count   = 0;
                m_starved = 0;
                m_phase   = MWait;
            end
            MWait: begin
                if (load) begin
                    m_phase = MFrame;
                    m_pos   = 0;
                end else if (!en) begin
                    m_phase = MIdle;
                end
            end
            default: begin
                if (m_pos < 3) begin
                    m_pos++;
                end else if (!en) begin
                    m_phase = MIdle;
                end else if (load) begin
                    m_pos = 0;
                end else begin
                    if (m_count >= PRIME) m_starved = 1;
                    m_phase = MWait;
                end
            end
        endcase
    endtask

    task automatic step(input logic en, input logic v, input logic rst);
        @(posedge clock);
        if (drv_rst) model_advance(drv_en, drv_v);
        #1;
        drv_en  = en;
        drv_v   = v;
        drv_rst = rst;
        if (!rst) model_reset();
        sb_q.push_back(model_out(en, v, rst));
    endtask

    // Run the stream until the model sits in frame slot p for the cycle just driven.
    task automatic run_to_pos(input int p);
        bit hit;
        hit = 0;
        for (int i = 0; i < 12; i++) begin
            if (m_phase == MFrame && m_pos == p) begin
                hit = 1;
                break;
            end
            step(1'b1, 1'b1, 1'b1);
        end
        check("reach_slot_bound", 32'(hit), 1);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("slot", 32'(slot), 32'(e.slot));
            check("in_ready", 32'(in_ready), 32'(e.in_ready));
            check("load_in", 32'(load_in), 32'(e.load_in));
            check("flush", 32'(flush), 32'(e.flush));
            check("lat_en", 32'(lat_en), 32'(e.lat_en));
            check("out_valid", 32'(out_valid), 32'(e.out_valid));
            check("frame_cnt", 32'(frame_cnt), 32'(e.frame_cnt));
            check("underrun", 32'(underrun), 32'(e.underrun));
        end
    end

    initial begin
        drv_rst = 1'b0;
        drv_en  = 1'b0;
        drv_v   = 1'b0;
        model_reset();

        repeat (3) step(1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b1);

        // Continuous stream through priming.
        repeat (120) step(1'b1, 1'b1, 1'b1);

        // Starve for 5 cycles starting at a slot 3, then resume.
        run_to_pos(2);
        repeat (5) step(1'b1, 1'b0, 1'b1);
        repeat (12) step(1'b1, 1'b1, 1'b1);

        // Drop enable in slot 1; frame completes without a load, then re-enable.
        run_to_pos(0);
        repeat (3) step(1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b1);
        repeat (30) step(1'b1, 1'b1, 1'b1);

        // Asynchronous reset in slot 2.
        run_to_pos(1);
        step(1'b1, 1'b1, 1'b0);
        #1;
        check("async_rst_slot", 32'(slot), 0);
        check("async_rst_lat_en", 32'(lat_en), 0);
        check("async_rst_frame_cnt", 32'(frame_cnt), 0);
        step(1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b1);
        repeat (40) step(1'b1, 1'b1, 1'b1);

        // Random traffic with stalls and enable drops.
        for (int i = 0; i < 2500; i++) begin
            logic en;
            logic v;
            en = ($urandom_range(0, 29) != 0);
            v  = ($urandom_range(0, 3) != 0);
            step(en, v, 1'b1);
        end

        // Long unbroken stream to saturate the sample counter.
        repeat (1300) step(1'b1, 1'b1, 1'b1);
        @(negedge clock);
        #1;
        check("sat_frame_cnt", 32'(frame_cnt), 255);
        check("sat_out_valid", 32'(out_valid), 1);
        check("sb_drained", 32'(sb_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
